// File: rtl/logic_pipe.sv
// logic_pipe: valid/ready pipelined bitwise logic unit (WIDTH-bit operands, STAGES-deep register chain).
// Define LOGIC_PIPE_PARITY_EN to add a parity output carried alongside each result.
module logic_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic                        clkpos,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  op,
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            result,
  output logic                        zero,
  output logic [$clog2(STAGES+1)-1:0] occupancy
`ifdef LOGIC_PIPE_PARITY_EN
  ,
  output logic                        parity
`endif
);

  localparam int OCC_W = $clog2(STAGES+1);

  function automatic logic [WIDTH-1:0] logic_op(
    input logic [2:0]       sel,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] r;
    case (sel)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = x ^ y;
      3'd3:    r = ~(x & y);
      3'd4:    r = ~(x | y);
      3'd5:    r = ~(x ^ y);
      3'd6:    r = x & ~y;
      3'd7:    r = x;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  logic [STAGES-1:0] v_r;
  logic [WIDTH-1:0]  data_r [STAGES];
  logic [STAGES-1:0] zero_r;
  logic [OCC_W-1:0]  occ_r;
  logic [STAGES-1:0] move_s;
  logic              accept_s;
  logic              emit_s;
  logic [WIDTH-1:0]  op_res_s;

  assign op_res_s = logic_op(op, a, b);

  // Stage i may move when any stage at or beyond i is empty, or the output is being taken.
  always_comb begin
    logic chain_s;
    move_s  = {STAGES{1'b0}};
    chain_s = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      chain_s   = chain_s | ~v_r[i];
      move_s[i] = chain_s;
    end
  end

  assign in_ready = move_s[0];
  assign accept_s = in_valid & move_s[0];
  assign emit_s   = v_r[STAGES-1] & out_ready;

  // Pipeline advance: a moving stage takes its predecessor's contents; stage 0 takes the new result.
  always_ff @(posedge clkpos or negedge rst_n) begin
    if (!rst_n) begin
      v_r    <= {STAGES{1'b0}};
      zero_r <= {STAGES{1'b0}};
      for (int i = 0; i < STAGES; i++) begin
        data_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (move_s[0]) begin
        v_r[0]    <= accept_s;
        data_r[0] <= op_res_s;
        zero_r[0] <= (op_res_s == {WIDTH{1'b0}});
      end
      for (int i = 1; i < STAGES; i++) begin
        if (move_s[i]) begin
          v_r[i]    <= v_r[i-1];
          data_r[i] <= data_r[i-1];
          zero_r[i] <= zero_r[i-1];
        end
      end
    end
  end

  // Occupancy tracks accepts minus emits; simultaneous accept and emit leave it unchanged.
  always_ff @(posedge clkpos or negedge rst_n) begin
    if (!rst_n) begin
      occ_r <= {OCC_W{1'b0}};
    end else begin
      case ({accept_s, emit_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1'b1);
        2'b01:   occ_r <= occ_r - OCC_W'(1'b1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign out_valid = v_r[STAGES-1];
  assign result    = data_r[STAGES-1];
  assign zero      = zero_r[STAGES-1];
  assign occupancy = occ_r;

`ifdef LOGIC_PIPE_PARITY_EN
  function automatic logic calc_parity(input logic [WIDTH-1:0] x);
    return ^x;
  endfunction

  logic [STAGES-1:0] par_r;

  // Parity is formed at entry and travels with its data word.
  always_ff @(posedge clkpos or negedge rst_n) begin
    if (!rst_n) begin
      par_r <= {STAGES{1'b0}};
    end else begin
      if (move_s[0]) begin
        par_r[0] <= calc_parity(op_res_s);
      end
      for (int i = 1; i < STAGES; i++) begin
        if (move_s[i]) begin
          par_r[i] <= par_r[i-1];
        end
      end
    end
  end

  assign parity = par_r[STAGES-1];
`endif

endmodule

// File: tb/tb_logic_pipe.sv
// Self-checking bench for logic_pipe: truth-table model with age-based timing plus directed literal checks.
module tb_logic_pipe;

  localparam int W = 16;
  localparam int S = 4;

  logic          clkpos = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero;
  logic [2:0]    occupancy;
`ifdef LOGIC_PIPE_PARITY_EN
  logic          parity;
`endif

  logic_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clkpos    (clkpos),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .occupancy (occupancy)
`ifdef LOGIC_PIPE_PARITY_EN
    ,
    .parity    (parity)
`endif
  );

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         p;
    int           edge_n;
  } item_t;

  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  item_t        exp_q[$];
  logic [W:0]   got_q[$];
  logic         rst_evt    = 1'b0;
  logic         rand_ready = 1'b0;
  logic         prev_stall = 1'b0;
  logic [2:0]   prev_op;
  logic [W-1:0] prev_a;
  logic [W-1:0] prev_b;

  always #5 clkpos = ~clkpos;

  always @(posedge clkpos) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-bit truth table indexed by {a_bit, b_bit}.
  function automatic logic [W-1:0] mdl(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [3:0]   tt;
    logic [W-1:0] r;
    case (o)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0110;
      3'd3:    tt = 4'b0111;
      3'd4:    tt = 4'b0001;
      3'd5:    tt = 4'b1001;
      3'd6:    tt = 4'b0100;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < W; i++) r[i] = tt[{x[i], y[i]}];
    return r;
  endfunction

  // Oldest item is presented once it has aged S-1 edges since acceptance.
  always @(negedge clkpos) begin
    item_t it;
    logic  exp_valid;
    logic  exp_ready;
    if (!rst_n || rst_evt) begin
      exp_q.delete();
      rst_evt    = 1'b0;
      prev_stall = 1'b0;
    end
    if (rst_n) begin
      exp_valid = (exp_q.size() > 0) && (cyc >= exp_q[0].edge_n + S - 1);
      exp_ready = (exp_q.size() < S) || out_ready;
      chk("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
        chk("result", result, exp_q[0].res);
        chk("zero", zero, exp_q[0].z);
`ifdef LOGIC_PIPE_PARITY_EN
        chk("parity", parity, exp_q[0].p);
`endif
      end
      chk("occupancy", occupancy, exp_q.size());
      chk("in_ready", in_ready, exp_ready);
      if (prev_stall) chk("hold_stable", {in_valid, op, a, b}, {1'b1, prev_op, prev_a, prev_b});
      prev_stall = in_valid && !exp_ready;
      prev_op = op;
      prev_a  = a;
      prev_b  = b;
      if (exp_valid && out_ready) begin
        got_q.push_back({zero, result});
        void'(exp_q.pop_front());
      end
      if (in_valid && exp_ready) begin
        it.res    = mdl(op, a, b);
        it.z      = (it.res == {W{1'b0}});
        it.p      = ^it.res;
        it.edge_n = cyc + 1;
        exp_q.push_back(it);
      end
    end
  end

  task automatic tick();
    @(posedge clkpos);
    #1;
  endtask

  task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input int max_cyc, output logic ok);
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    ok = 1'b0;
    for (int n = 0; n < max_cyc && !ok; n++) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      #1;
      ok = in_ready;
      @(posedge clkpos);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      tick();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    tick();
  endtask

  logic [15:0] ops_exp [8] = '{16'h8888, 16'hEEEE, 16'h6666, 16'h7777,
                               16'h1111, 16'h9999, 16'h2222, 16'hAAAA};
  logic [15:0] set_a [6]   = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606};

  initial begin
    logic ok;
    int   idx;
    int   n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 3'd0;
    a         = 16'h0000;
    b         = 16'h0000;
    out_ready = 1'b1;

    // Reset state
    #11;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 16'h0000);
    chk("rst_zero", zero, 1'b0);
    chk("rst_occupancy", occupancy, 3'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1'b1);

    // Single op and latency
    got_q.delete();
    send(3'd0, 16'hF0F0, 16'hFF00, 5, ok);
    chk("t1_accept", ok, 1'b1);
    chk("t1_lat_e0", out_valid, 1'b0);
    tick();
    chk("t1_lat_e1", out_valid, 1'b0);
    tick();
    chk("t1_lat_e2", out_valid, 1'b0);
    tick();
    chk("t1_lat_e3", out_valid, 1'b1);
    chk("t1_result", result, 16'hF000);
    chk("t1_zero", zero, 1'b0);
    drain(10);

    // All ops streamed back-to-back
    got_q.delete();
    for (int i = 0; i < 8; i++) begin
      send(3'(i), 16'hAAAA, 16'hCCCC, 3, ok);
      chk("t2_accept", ok, 1'b1);
      if (i == 5) chk("t2_occ_steady", occupancy, 3'd4);
    end
    drain(20);
    chk("t2_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) chk("t2_op_result", got_q[i][15:0], ops_exp[i]);

    // Zero flag
    got_q.delete();
    send(3'd0, 16'h00FF, 16'hFF00, 3, ok);
    send(3'd2, 16'h00FF, 16'hFF00, 3, ok);
    drain(20);
    chk("t3_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("t3_and_zero", got_q[0], {1'b1, 16'h0000});
      chk("t3_xor_nonzero", got_q[1], {1'b0, 16'hFFFF});
    end

    // Backpressure: only S sets fit while out_ready is low
    got_q.delete();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      op = 3'd7;
      a  = set_a[idx];
      b  = 16'h0000;
      #1;
      if (in_ready) idx++;
      @(posedge clkpos);
      #1;
    end
    chk("t4_accepted", idx, 4);
    chk("t4_in_ready_full", in_ready, 1'b0);
    chk("t4_occ_full", occupancy, 3'd4);
    out_ready = 1'b1;
    n = 0;
    while (idx < 6 && n < 20) begin
      send(3'd7, set_a[idx], 16'h0000, 5, ok);
      if (ok) idx++;
      n++;
    end
    chk("t4_all_accepted", idx, 6);
    drain(20);
    chk("t4_count", got_q.size(), 6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) chk("t4_order", got_q[i][15:0], set_a[i]);

    // Bubbles with random backpressure
    got_q.delete();
    rand_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 40, ok);
      chk("t5_accept", ok, 1'b1);
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    rand_ready = 1'b0;
    drain(40);
    chk("t5_count", got_q.size(), 12);

    // Reset mid-stream
    got_q.delete();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) send(3'd1, 16'(i), 16'h0000, 3, ok);
    chk("t6_occ3", occupancy, 3'd3);
    tick();
    chk("t6_front_valid", out_valid, 1'b1);
    chk("t6_front_result", result, 16'h0001);
    rst_n   = 1'b0;
    rst_evt = 1'b1;
    #1;
    chk("t6_rst_out_valid", out_valid, 1'b0);
    chk("t6_rst_result", result, 16'h0000);
    chk("t6_rst_zero", zero, 1'b0);
    chk("t6_rst_occ", occupancy, 3'd0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (8) tick();
    chk("t6_no_stale", got_q.size(), 0);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_pipe.md
# logic_pipe

Parametrised, pipelined bitwise logic unit for the MIPS25 ALU. It is the successor to the fixed 16-bit AND array: it has configurable width and depth, eight selectable bitwise operations, and a valid/ready handshake with full backpressure. Its STAGES-deep register pipeline models the phase latency of the adiabatic logic cascade. The block sits between the operand-select stage and the ALU result mux, alongside the adder.

## Interface
Parameters:
- WIDTH, 16, operand and result width in bits (≥1)
- STAGES, 4, pipeline depth in registers (≥1)

Ports:
- clkpos  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  operand set presented
- in_ready  output  1  block can accept this cycle
- op  input  3  operation select, sampled with operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result presented
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  operation result
- zero  output  1  result == 0, aligned with result
- occupancy  output  $clog2(STAGES+1)  number of valid stages held

## Operation
- op encoding:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR
  - 6 ANDN (a & ~b), 7 PASSA (a)
- Computation is combinational on a, b and op at the input. It is registered into stage 0 on acceptance.
- Each stage i holds {v[i], data[i], zero[i]}. Stage STAGES-1 drives out_valid, result and zero.
- Stage advance rules:
  - Stage STAGES-1 may move when its v is 0 or out_ready = 1.
  - Stage i < STAGES-1 may move when stage i+1 is empty or stage i+1 may move.
  - Bubbles collapse: an empty stage always accepts from its predecessor.
- in_ready = stage 0 may move. Acceptance = in_valid & in_ready.
- When a stage moves and receives nothing, its v clears. data is don't-care when v = 0.
- occupancy = number of set v bits.
  - It is +1 on acceptance without output transfer and -1 on output transfer without acceptance.
  - It is unchanged when both happen or neither happens.
- Results leave in acceptance order. No transfer is dropped or duplicated.
- in_valid must not be retracted and a/b/op must stay stable while in_valid=1 & in_ready=0. A bench assertion checks this; the block does not enforce it.

## Timing
- Reset (rst_n = 0, asynchronous):
  - All v clear, data and zero registers clear.
  - out_valid = 0, result = 0, zero = 0, occupancy = 0.
  - in_ready = 1 from the first cycle after reset deassertion.
- Reset mid-operation discards all in-flight results. Nothing is emitted after deassertion until new acceptances occur.
- Latency with no stall: a set accepted at edge k is presented with out_valid = 1 after edge k+STAGES-1. This is STAGES cycles counted from the accept cycle.
- Throughput is one result per cycle when out_ready is held at 1.
- Full condition:
  - All STAGES stages are valid and out_ready = 0.
  - in_ready = 0 combinationally and occupancy = STAGES.
- out_ready rising while full lets in_ready rise in the same cycle. Accept and emit then happen on the same edge and occupancy stays at STAGES.
- in_ready depends combinationally on out_ready; there is no skid buffer. out_valid, result and zero are direct register outputs.
- STAGES = 1: in_ready = !v[0] | out_ready.

## Configuration
- LOGIC_PIPE_PARITY_EN defined:
  - Adds output port parity (1 bit) = ^result, computed at stage 0 and carried with the data.
  - Reset value 0, aligned with result.
- Not defined: no parity port and no parity register. All other behaviour is identical.

## Test plan
- Reset then single op: with WIDTH=16 and STAGES=4, accept a=16'hF0F0, b=16'hFF00, op=0 at edge 0.
  - result=16'hF000, zero=0, out_valid first high after edge 3.
- All ops: with a=16'hAAAA, b=16'hCCCC, stream op 0–7 back-to-back with out_ready=1. Expect in order:
  - 8888, EEEE, 6666, 7777, 1111, 9999, 2222, AAAA
  - One result per cycle, occupancy steady at 4.
- Zero flag: a=16'h00FF, b=16'hFF00, op=0 -> result=0, zero=1. With LOGIC_PIPE_PARITY_EN, op=2 gives result=16'hFFFF and parity=0.
- Backpressure: hold out_ready=0 and offer 6 sets.
  - Exactly 4 are accepted, in_ready=0, occupancy=4.
  - Release out_ready: all 6 results emerge in order with no loss or duplicates.
- Bubbles: accept in alternating cycles while toggling out_ready randomly. The scoreboard matches order and values, and occupancy equals accepted minus emitted at every cycle.
- Reset mid-stream: with occupancy=3, pulse rst_n low between edges.
  - Outputs go to 0 immediately and occupancy=0.
  - No stale result appears after deassertion.
